// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Resolves one control-transfer instruction per cycle (six conditional
// branch types, JAL, JALR) and presents a registered result to the
// PC-redirect logic. It also holds a table of 2-bit saturating predictor
// counters. Fetch reads this table combinationally, and every resolved
// legal conditional branch trains it. Two saturating counters track
// resolved instructions and mispredicts.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_pc, in_rs1, in_rs2 instruction PC and operand values
//   in_imm                sign-extended immediate
//   in_funct3             branch condition code
//   in_kind               00 branch, 01 JAL, 10 JALR, 11 illegal
//   in_pred_taken         prediction fetch used for this instruction
//   out_valid / out_ready output handshake
//   out_taken, out_mispredict, out_misaligned, out_illegal   result flags
//   out_target            resolved next PC
//   out_link              in_pc + 4
//   lookup_pc             fetch PC to predict
//   lookup_taken          MSB of the predictor counter for lookup_pc
//   stat_branches, stat_mispredicts   saturating statistics
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = !out_valid | out_ready, so it never depends on
// in_valid. While out_valid & !out_ready, all out_* signals hold stable.

module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int PHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_kind,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_misaligned,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [1:0]      pht [PHT_DEPTH];
    logic            accept;
    logic            cond;
    logic            legal_branch;
    logic            nxt_taken;
    logic            nxt_mispredict;
    logic            nxt_misaligned;
    logic            nxt_illegal;
    logic [XLEN-1:0] nxt_target;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] look_idx;
    logic            unused_lookup_bits;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign pc_plus4    = in_pc + XLEN'(4);
    assign pc_plus_imm = in_pc + in_imm;
    assign jalr_sum    = in_rs1 + in_imm;

    assign upd_idx  = in_pc[IDX_W+1:2];
    assign look_idx = lookup_pc[IDX_W+1:2];
    // The predictor is indexed by a slice of the fetch PC. The other bits
    // are intentionally ignored, so PCs that differ only there alias.
    assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    // Counter MSB = predict taken. Reading while the same entry is being
    // trained returns the value before the update.
    assign lookup_taken = pht[look_idx][1];

    always_comb begin
        cond = 1'b0;
        unique case (in_funct3)
            3'b000:  cond = (in_rs1 == in_rs2);
            3'b001:  cond = (in_rs1 != in_rs2);
            3'b100:  cond = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  cond = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  cond = (in_rs1 <  in_rs2);
            3'b111:  cond = (in_rs1 >= in_rs2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        nxt_taken      = 1'b0;
        nxt_illegal    = 1'b0;
        nxt_mispredict = in_pred_taken;
        nxt_target     = pc_plus4;
        legal_branch   = 1'b0;
        unique case (in_kind)
            2'b00: begin
                if (in_funct3 == 3'b010 || in_funct3 == 3'b011) begin
                    nxt_illegal = 1'b1;
                end else begin
                    legal_branch   = 1'b1;
                    nxt_taken      = cond;
                    nxt_target     = cond ? pc_plus_imm : pc_plus4;
                    nxt_mispredict = cond ^ in_pred_taken;
                end
            end
            2'b01: begin
                nxt_taken      = 1'b1;
                nxt_target     = pc_plus_imm;
                nxt_mispredict = !in_pred_taken;
            end
            2'b10: begin
                // There is no target prediction, so a JALR always counts as
                // mispredicted.
                nxt_taken      = 1'b1;
                nxt_target     = jalr_sum;
                nxt_target[0]  = 1'b0;
                nxt_mispredict = 1'b1;
            end
            default: begin
                nxt_illegal = 1'b1;
            end
        endcase
        nxt_misaligned = nxt_taken && (nxt_target[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_taken        <= 1'b0;
            out_mispredict   <= 1'b0;
            out_misaligned   <= 1'b0;
            out_illegal      <= 1'b0;
            out_target       <= '0;
            out_link         <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else begin
            if (accept) begin
                // Loading on accept also covers a same-cycle pop: the new
                // result replaces the old one and out_valid stays high.
                out_valid      <= 1'b1;
                out_taken      <= nxt_taken;
                out_mispredict <= nxt_mispredict;
                out_misaligned <= nxt_misaligned;
                out_illegal    <= nxt_illegal;
                out_target     <= nxt_target;
                out_link       <= pc_plus4;
                if (stat_branches != '1) begin
                    stat_branches <= stat_branches + CNT_W'(1);
                end
                if (nxt_mispredict && stat_mispredicts != '1) begin
                    stat_mispredicts <= stat_mispredicts + CNT_W'(1);
                end
                if (legal_branch) begin
                    if (nxt_taken && pht[upd_idx] != 2'b11) begin
                        pht[upd_idx] <= pht[upd_idx] + 2'b01;
                    end else if (!nxt_taken && pht[upd_idx] != 2'b00) begin
                        pht[upd_idx] <= pht[upd_idx] - 2'b01;
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vector table, hand-written
// backpressure/reset/predictor sequences, and a randomized run against a
// behavioural model with an expected-result queue.

module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CNT_W = 32;
    localparam int RW    = 4 + 2 * XLEN;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic [2:0]       in_funct3 = '0;
    logic [1:0]       in_kind = '0;
    logic             in_pred_taken = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_taken, out_mispredict, out_misaligned, out_illegal;
    logic [XLEN-1:0]  out_target, out_link;
    logic [XLEN-1:0]  lookup_pc = '0;
    logic             lookup_taken;
    logic [CNT_W-1:0] stat_branches, stat_mispredicts;
    logic [RW-1:0]    dut_res;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .PHT_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_funct3(in_funct3), .in_kind(in_kind), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_misaligned(out_misaligned), .out_illegal(out_illegal),
        .out_target(out_target), .out_link(out_link),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    assign dut_res = {out_taken, out_mispredict, out_misaligned, out_illegal, out_target, out_link};

    typedef struct {
        logic [XLEN-1:0] pc, rs1, rs2, imm;
        logic [2:0]      f3;
        logic [1:0]      kind;
        logic            pred;
        logic            taken, mp, misal, ill;
        logic [XLEN-1:0] target;
    } vec_t;

    vec_t          vecs[$];
    logic [RW-1:0] exp_q[$];
    int            pht_m[DEPTH];
    longint        exp_br, exp_mp;
    int            n_checks = 0;
    int            n_pass = 0;

    // ---------------- scoreboard / model ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) pht_m[i] = 1;
        exp_br = 0;
        exp_mp = 0;
    endfunction

    function automatic int pht_index(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic logic model_lookup(input logic [XLEN-1:0] pc);
        return pht_m[pht_index(pc)] >= 2;
    endfunction

    // Resolves one instruction from the ISA rules and applies its side
    // effects (statistics, predictor training) to the model.
    function automatic logic [RW-1:0] model_accept(
        input logic [XLEN-1:0] pc, rs1, rs2, imm,
        input logic [2:0] f3, input logic [1:0] kind, input logic pred);
        longint s1, s2, u1, u2;
        logic taken, ill, mp;
        logic [XLEN-1:0] tgt, sum;
        s1 = longint'($signed(rs1));
        s2 = longint'($signed(rs2));
        u1 = longint'({32'd0, rs1});
        u2 = longint'({32'd0, rs2});
        taken = 1'b0;
        ill = 1'b0;
        mp = pred;
        tgt = pc + 4;
        if (kind == 2'd0) begin
            case (f3)
                3'd0: taken = (u1 == u2);
                3'd1: taken = (u1 != u2);
                3'd4: taken = (s1 < s2);
                3'd5: taken = (s1 >= s2);
                3'd6: taken = (u1 < u2);
                3'd7: taken = (u1 >= u2);
                default: ill = 1'b1;
            endcase
            if (!ill) begin
                tgt = taken ? pc + imm : pc + 4;
                mp = (taken != pred);
                if (taken) pht_m[pht_index(pc)] = (pht_m[pht_index(pc)] == 3) ? 3 : pht_m[pht_index(pc)] + 1;
                else       pht_m[pht_index(pc)] = (pht_m[pht_index(pc)] == 0) ? 0 : pht_m[pht_index(pc)] - 1;
            end
        end else if (kind == 2'd1) begin
            taken = 1'b1;
            tgt = pc + imm;
            mp = !pred;
        end else if (kind == 2'd2) begin
            taken = 1'b1;
            sum = rs1 + imm;
            tgt = sum - (sum % 2);
            mp = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (exp_br < 64'hFFFF_FFFF) exp_br++;
        if (mp && exp_mp < 64'hFFFF_FFFF) exp_mp++;
        return {taken, mp, taken && (tgt % 4 != 0), ill, tgt, pc + 32'd4};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [XLEN-1:0] pc, rs1, rs2, imm,
                         input logic [2:0] f3, input logic [1:0] kind, input logic pred);
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_funct3 = f3; in_kind = kind; in_pred_taken = pred;
    endtask

    task automatic drive_vec(input vec_t v);
        drive(v.pc, v.rs1, v.rs2, v.imm, v.f3, v.kind, v.pred);
    endtask

    task automatic add_vec(input logic [XLEN-1:0] pc, rs1, rs2, imm,
                           input logic [2:0] f3, input logic [1:0] kind, input logic pred,
                           input logic taken, mp, misal, ill, input logic [XLEN-1:0] target);
        vec_t v;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.f3 = f3; v.kind = kind;
        v.pred = pred; v.taken = taken; v.mp = mp; v.misal = misal; v.ill = ill;
        v.target = target;
        vecs.push_back(v);
    endtask

    function automatic logic [RW-1:0] vec_exp(input vec_t v);
        return {v.taken, v.mp, v.misal, v.ill, v.target, v.pc + 32'd4};
    endfunction

    task automatic check_stats(input string name);
        check({name, " stat_branches"}, 128'(stat_branches), 128'(exp_br));
        check({name, " stat_mispredicts"}, 128'(stat_mispredicts), 128'(exp_mp));
    endtask

    // Hands one instruction to the DUT with out_ready=1 and checks the result.
    task automatic send_and_check(input string name, input vec_t v);
        logic [RW-1:0] r;
        drive_vec(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        r = model_accept(v.pc, v.rs1, v.rs2, v.imm, v.f3, v.kind, v.pred);
        tick();
        in_valid = 1'b0;
        check({name, " out_valid"}, 128'(out_valid), 128'(1));
        check({name, " result"}, 128'(dut_res), 128'(r));
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        logic [RW-1:0] r;
        logic [RW-1:0] held;
        logic pop, acc;
        logic [XLEN-1:0] rnd;

        //       pc            rs1           rs2           imm           f3    kind  pr  tk mp ma il target
        add_vec(32'h100,      32'd5,        32'd5,        32'h20,       3'd5, 2'd0, 0,  1, 1, 0, 0, 32'h120);
        add_vec(32'h3A8,      32'hFFFFFFFF, 32'd1,        32'h40,       3'd4, 2'd0, 0,  1, 1, 0, 0, 32'h3E8);
        add_vec(32'h3A8,      32'hFFFFFFFF, 32'd1,        32'h40,       3'd6, 2'd0, 0,  0, 0, 0, 0, 32'h3AC);
        add_vec(32'h500,      32'h1001,     32'd0,        32'd2,        3'd0, 2'd2, 0,  1, 1, 1, 0, 32'h1002);
        add_vec(32'h200,      32'd0,        32'd0,        32'h10,       3'd0, 2'd1, 1,  1, 0, 0, 0, 32'h210);
        add_vec(32'h6F0,      32'd7,        32'd7,        32'hFFFFFFF8, 3'd0, 2'd0, 1,  1, 0, 0, 0, 32'h6E8);
        add_vec(32'h6F0,      32'd7,        32'd7,        32'hFFFFFFF8, 3'd1, 2'd0, 1,  0, 1, 0, 0, 32'h6F4);
        add_vec(32'h724,      32'd1,        32'hFFFFFFFF, 32'h10,       3'd7, 2'd0, 0,  0, 0, 0, 0, 32'h728);
        add_vec(32'h800,      32'd0,        32'd0,        32'h10,       3'd2, 2'd0, 1,  0, 1, 0, 1, 32'h804);
        add_vec(32'h900,      32'd3,        32'd3,        32'h10,       3'd0, 2'd3, 0,  0, 0, 0, 1, 32'h904);
        add_vec(32'h100,      32'd0,        32'd0,        32'd6,        3'd0, 2'd0, 1,  1, 0, 1, 0, 32'h106);
        add_vec(32'hA00,      32'hFFFFFFFF, 32'd0,        32'd4,        3'd0, 2'd2, 1,  1, 1, 1, 0, 32'h2);
        add_vec(32'hB14,      32'hFFFFFFFE, 32'd1,        32'd8,        3'd5, 2'd0, 1,  0, 1, 0, 0, 32'hB18);
        add_vec(32'hC10,      32'd9,        32'd9,        32'h8,        3'd7, 2'd0, 0,  1, 1, 0, 0, 32'hC18);

        // ---- reset state ----
        model_reset();
        #1;
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset in_ready", 128'(in_ready), 128'(1));
        check("reset outputs", 128'(dut_res), 128'(0));
        check_stats("reset");
        check("reset lookup", 128'(lookup_taken), 128'(0));
        @(posedge clk);
        tick();
        rst = 1'b0;

        // ---- directed vector table ----
        foreach (vecs[i]) begin
            drive_vec(vecs[i]);
            in_valid = 1'b1;
            out_ready = 1'b1;
            void'(model_accept(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                               vecs[i].f3, vecs[i].kind, vecs[i].pred));
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d result", i), 128'(dut_res), 128'(vec_exp(vecs[i])));
            check_stats($sformatf("vec%0d", i));
        end
        tick();
        check("drain out_valid", 128'(out_valid), 128'(0));
        for (int i = 0; i < DEPTH; i++) begin
            lookup_pc = 32'(i * 4);
            #1;
            check($sformatf("pht idx%0d", i), 128'(lookup_taken), 128'(model_lookup(lookup_pc)));
        end

        // ---- backpressure ----
        drive(32'h44, 32'd1, 32'd1, 32'h100, 3'd0, 2'd0, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        check("bp first in_ready", 128'(in_ready), 128'(1));
        held = model_accept(32'h44, 32'd1, 32'd1, 32'h100, 3'd0, 2'd0, 1'b0);
        tick();
        drive(32'h80, 32'd0, 32'd0, 32'h8, 3'd0, 2'd1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d in_ready", c), 128'(in_ready), 128'(0));
            check($sformatf("bp%0d out_valid", c), 128'(out_valid), 128'(1));
            check($sformatf("bp%0d held result", c), 128'(dut_res), 128'(held));
            check_stats($sformatf("bp%0d", c));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 128'(in_ready), 128'(1));
        r = model_accept(32'h80, 32'd0, 32'd0, 32'h8, 3'd0, 2'd1, 1'b1);
        tick();
        check("bp pop+accept out_valid", 128'(out_valid), 128'(1));
        check("bp second result", 128'(dut_res), 128'(r));
        for (int i = 4; i < 8; i++) begin
            drive_vec(vecs[i]);
            void'(model_accept(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                               vecs[i].f3, vecs[i].kind, vecs[i].pred));
            tick();
            check($sformatf("stream%0d out_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("stream%0d result", i), 128'(dut_res), 128'(vec_exp(vecs[i])));
        end
        check_stats("stream");
        in_valid = 1'b0;
        tick();

        // ---- reset mid-stream with a pending result ----
        v = vecs[0];
        drive_vec(v);
        in_valid = 1'b1;
        out_ready = 1'b0;
        void'(model_accept(v.pc, v.rs1, v.rs2, v.imm, v.f3, v.kind, v.pred));
        tick();
        in_valid = 1'b0;
        lookup_pc = 32'h100;
        #1;
        check("pre-reset out_valid", 128'(out_valid), 128'(1));
        check("pre-reset lookup 0x100", 128'(lookup_taken), 128'(model_lookup(32'h100)));
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async reset out_valid", 128'(out_valid), 128'(0));
        check("async reset outputs", 128'(dut_res), 128'(0));
        check("async reset in_ready", 128'(in_ready), 128'(1));
        check_stats("async reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_pc = 32'(i * 4);
            #1;
            check($sformatf("post-reset pht idx%0d", i), 128'(lookup_taken), 128'(0));
        end

        // ---- predictor training at pc 0x40 ----
        lookup_pc = 32'h40;
        v.pc = 32'h40; v.rs1 = 32'd9; v.rs2 = 32'd9; v.imm = 32'h10;
        v.f3 = 3'd0; v.kind = 2'd0; v.pred = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_vec(v);
            #1;
            check($sformatf("train%0d lookup", k), 128'(lookup_taken), 128'(k == 0 ? 0 : 1));
            send_and_check($sformatf("train%0d", k), v);
        end
        check("saturated lookup 0x40", 128'(lookup_taken), 128'(1));
        lookup_pc = 32'h140;
        #1;
        check("alias lookup 0x140", 128'(lookup_taken), 128'(1));
        lookup_pc = 32'h40;
        v.rs2 = 32'd8;
        send_and_check("untrain1", v);
        check("after untrain1 lookup", 128'(lookup_taken), 128'(1));
        v.f3 = 3'd2;
        send_and_check("illegal f3 010", v);
        check("illegal f3 no pht change", 128'(lookup_taken), 128'(1));
        v.f3 = 3'd0; v.kind = 2'd3;
        send_and_check("illegal kind 11", v);
        check("illegal kind no pht change", 128'(lookup_taken), 128'(1));
        v.kind = 2'd0;
        send_and_check("untrain2", v);
        check("after untrain2 lookup", 128'(lookup_taken), 128'(0));
        check_stats("train");
        tick();

        // ---- randomized run against the model ----
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            check($sformatf("rnd%0d out_valid", c), 128'(out_valid), 128'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check($sformatf("rnd%0d result", c), 128'(dut_res), 128'(exp_q[0]));
            check_stats($sformatf("rnd%0d", c));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_pc     = 32'($urandom_range(0, 511)) << 2;
            in_rs1    = $urandom;
            in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
            rnd       = $urandom;
            in_imm    = {{20{rnd[11]}}, rnd[11:0]};
            in_funct3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                5:       in_kind = 2'd1;
                6:       in_kind = 2'd2;
                7:       in_kind = 2'd3;
                default: in_kind = 2'd0;
            endcase
            in_pred_taken = 1'($urandom_range(0, 1));
            lookup_pc = ($urandom_range(0, 1) == 0) ? in_pc : 32'($urandom_range(0, 511)) << 2;
            #1;
            check($sformatf("rnd%0d in_ready", c), 128'(in_ready), 128'(exp_q.size() == 0 || out_ready));
            check($sformatf("rnd%0d lookup", c), 128'(lookup_taken), 128'(model_lookup(lookup_pc)));
            pop = (exp_q.size() != 0) && out_ready;
            acc = in_valid && ((exp_q.size() == 0) || out_ready);
            if (acc)
                r = model_accept(in_pc, in_rs1, in_rs2, in_imm, in_funct3, in_kind, in_pred_taken);
            tick();
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
